conv_acc_25p: RTL and testbench



---
 rtl/conv_acc_25p.sv | 182 ++++++++++++++++++
 tb/tb_conv_acc_25p.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_25p.sv
// rtl/conv_acc_25p.sv - 25-product window reducer with channel accumulation, bias and saturation
//
// Purpose:
//   Takes one 5x5 window of signed fixed-point products per beat, reduces the
//   25 products with a three-stage pipelined adder tree, and accumulates the
//   reduced value over CH_NUM input-channel beats. On the last channel beat
//   the bias is added, the result is clamped to WIDTH bits and emitted as a
//   single-cycle out_valid pulse.
//
//   Products, bias and output all share POINT_WIDTH fractional bits, so the
//   datapath is a plain integer sum with no realignment.
//
// Optional feature:
//   CONV_ACC_RELU_EN - when defined, negative saturated results are replaced
//   by zero before being registered into out_data. Latency is unchanged.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          inP_25P holds a valid product window
//   inP_25P    in   WIDTH*25   packed products, element 0 at the LSBs
//   bias       in   WIDTH      signed bias, used on the last channel beat only
//   out_valid  out  1          one-cycle pulse when out_data is new
//   out_data   out  WIDTH      saturated signed result
//   busy       out  1          a partial sum is pending (channel count != 0)

module conv_acc_25p #(
  parameter int WIDTH       = 16,
  parameter int POINT_WIDTH = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int CH_NUM      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH*25-1:0]   inP_25P,
  input  logic [WIDTH-1:0]      bias,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy
);

  // A counter of at least one bit keeps the CH_NUM=1 build legal; in that
  // case the counter simply stays at zero and every beat is the last one.
  localparam int CNT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  // Clamp limits expressed at accumulator width so the compare is exact.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // The accumulator must hold 25 * CH_NUM worst-case products plus bias, and
  // the fraction must leave at least a sign bit; reject builds that break this.
  if ((ACC_WIDTH < WIDTH + 5 + $clog2(CH_NUM)) || (POINT_WIDTH >= WIDTH)) begin : gParamCheck
    $error("conv_acc_25p: ACC_WIDTH too small or POINT_WIDTH too large");
  end

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Channel counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] chCnt;
  logic             isLast;

  assign isLast = (chCnt == CNT_W'(CH_NUM - 1));
  assign busy   = (chCnt != '0);

  // ---------------------------------------------------------------------------
  // Stage 1: five partial sums of five sign-extended products each
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] partSum [5];
  logic signed [ACC_WIDTH-1:0] s1Part  [5];
  logic                        s1Valid;
  logic                        s1Last;
  logic        [WIDTH-1:0]     s1Bias;

  always_comb begin
    for (int j = 0; j < 5; j++) begin
      partSum[j] = '0;
      for (int k = 0; k < 5; k++) begin
        partSum[j] = partSum[j] + sext(inP_25P[WIDTH*(5*j+k) +: WIDTH]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum of the five partial sums
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] treeSum;
  logic signed [ACC_WIDTH-1:0] s2Sum;
  logic                        s2Valid;
  logic                        s2Last;
  logic        [WIDTH-1:0]     s2Bias;

  always_comb begin
    treeSum = '0;
    for (int j = 0; j < 5; j++) begin
      treeSum = treeSum + s1Part[j];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: accumulate, or finish the frame with bias and saturation
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] finalSum;
  logic        [WIDTH-1:0]     satVal;
  logic        [WIDTH-1:0]     resVal;

  // Only meaningful when the stage-2 beat is the last channel of a frame.
  assign finalSum = acc + s2Sum + sext(s2Bias);

  always_comb begin
    if (finalSum > SAT_MAX) begin
      satVal = SAT_MAX[WIDTH-1:0];
    end else if (finalSum < SAT_MIN) begin
      satVal = SAT_MIN[WIDTH-1:0];
    end else begin
      satVal = finalSum[WIDTH-1:0];
    end
`ifdef CONV_ACC_RELU_EN
    resVal = satVal[WIDTH-1] ? '0 : satVal;
`else
    resVal = satVal;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control and accumulator state (cleared by reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      chCnt     <= '0;
      s1Valid   <= 1'b0;
      s1Last    <= 1'b0;
      s2Valid   <= 1'b0;
      s2Last    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1Valid <= in_valid;
      s1Last  <= in_valid && isLast;
      if (in_valid) begin
        chCnt <= isLast ? '0 : chCnt + CNT_W'(1);
      end

      s2Valid <= s1Valid;
      s2Last  <= s1Last;

      out_valid <= 1'b0;
      if (s2Valid) begin
        if (s2Last) begin
          out_data  <= resVal;
          out_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc + s2Sum;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline data registers; qualified by the valid/last tags, so no reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1Part <= partSum;
      if (isLast) begin
        s1Bias <= bias;
      end
    end
    s2Sum  <= treeSum;
    s2Bias <= s1Bias;
  end

endmodule

// File: tb/tb_conv_acc_25p.sv
// tb/tb_conv_acc_25p.sv - self-checking bench for conv_acc_25p (CH_NUM=1 and CH_NUM=6 instances)

module tb_conv_acc_25p;

  localparam int W = 16;
  localparam int N = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 drives the CH_NUM=1 instance, index 1 the CH_NUM=6 instance.
  logic             inValid  [2];
  logic [W*N-1:0]   inP      [2];
  logic [W-1:0]     biasIn   [2];
  logic             outValid [2];
  logic [W-1:0]     outData  [2];
  logic             busy     [2];

  conv_acc_25p #(.WIDTH(16), .POINT_WIDTH(8), .ACC_WIDTH(32), .CH_NUM(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .inP_25P(inP[0]), .bias(biasIn[0]),
    .out_valid(outValid[0]), .out_data(outData[0]), .busy(busy[0])
  );

  conv_acc_25p #(.WIDTH(16), .POINT_WIDTH(8), .ACC_WIDTH(32), .CH_NUM(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .inP_25P(inP[1]), .bias(biasIn[1]),
    .out_valid(outValid[1]), .out_data(outData[1]), .busy(busy[1])
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frame sum of all products, bias from the last beat,
  // clamp to 16 bits; the result is due three cycles after the beat is driven.
  // ---------------------------------------------------------------------------
  int          chNum [2] = '{1, 6};
  longint      fAcc  [2];
  int          cnt   [2];
  bit          pendV   [2][4];
  int unsigned pendDue [2][4];
  logic [15:0] pendVal [2][4];
  int          pulseCnt [2];
  logic [15:0] lastOut  [2];
  logic [15:0] prevOut  [2];
  int unsigned lastCyc  [2];
  int unsigned prevCyc  [2];

  function automatic longint sumOf(input logic [W*N-1:0] v);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'($signed(v[W*k +: W]));
    return s;
  endfunction

  function automatic logic [15:0] satRelu(input longint s);
    logic [15:0] r;
    if (s > 32767) r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else r = 16'(s);
`ifdef CONV_ACC_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  initial begin : compare
    int  s;
    bit  e;
    int unsigned due;
    for (int i = 0; i < 2; i++) begin
      fAcc[i] = 0; cnt[i] = 0; pulseCnt[i] = 0;
      lastOut[i] = '0; prevOut[i] = '0; lastCyc[i] = 0; prevCyc[i] = 0;
      for (int j = 0; j < 4; j++) pendV[i][j] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s = int'(cyc % 4);
        e = pendV[i][s] && (pendDue[i][s] == cyc);
        check($sformatf("u%0d out_valid", i), {31'b0, outValid[i]}, {31'b0, e});
        if (e) begin
          check($sformatf("u%0d out_data", i), {16'b0, outData[i]}, {16'b0, pendVal[i][s]});
          pendV[i][s] = 1'b0;
        end
        check($sformatf("u%0d busy", i), {31'b0, busy[i]}, {31'b0, cnt[i] != 0});
        if (outValid[i] === 1'b1) begin
          pulseCnt[i]++;
          prevOut[i] = lastOut[i]; lastOut[i] = outData[i];
          prevCyc[i] = lastCyc[i]; lastCyc[i] = cyc;
        end
        // Inputs now on the bus are sampled at the next rising edge.
        if (rst) begin
          fAcc[i] = 0; cnt[i] = 0;
          for (int j = 0; j < 4; j++) pendV[i][j] = 1'b0;
        end else if (inValid[i]) begin
          fAcc[i] += sumOf(inP[i]);
          cnt[i]++;
          if (cnt[i] == chNum[i]) begin
            due = cyc + 3;
            pendV[i][due % 4]   = 1'b1;
            pendDue[i][due % 4] = due;
            pendVal[i][due % 4] = satRelu(fAcc[i] + longint'($signed(biasIn[i])));
            fAcc[i] = 0; cnt[i] = 0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  function automatic logic [W*N-1:0] fill(input logic [15:0] p);
    logic [W*N-1:0] r;
    for (int k = 0; k < N; k++) r[W*k +: W] = p;
    return r;
  endfunction

  task automatic beat(input int i, input logic [W*N-1:0] v, input logic [15:0] b);
    @(posedge clk); #1;
    inValid[0] = 1'b0; inValid[1] = 1'b0;
    inValid[i] = 1'b1; inP[i] = v; biasIn[i] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      inValid[0] = 1'b0; inValid[1] = 1'b0;
    end
  endtask

  task automatic abortFrame(input logic [15:0] p);
    for (int c = 0; c < 3; c++) beat(1, fill(p), 16'h0000);
    @(posedge clk); #1;
    inValid[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int p;
    logic [W*N-1:0] v;
    logic [15:0] expNeg;
    for (int i = 0; i < 2; i++) begin
      inValid[i] = 1'b0; inP[i] = '0; biasIn[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset u%0d out_valid", i), {31'b0, outValid[i]}, 32'h0);
      check($sformatf("reset u%0d out_data", i), {16'b0, outData[i]}, 32'h0);
      check($sformatf("reset u%0d busy", i), {31'b0, busy[i]}, 32'h0);
    end
    rst = 1'b0;

    // 1: single beat, CH_NUM=1, 25*1.0 + 0.5
    p = pulseCnt[0];
    beat(0, fill(16'h0100), 16'h0080);
    idle(5);
    check("t1 pulses", pulseCnt[0] - p, 1);
    check("t1 data", {16'b0, lastOut[0]}, 32'h1980);

    // 2: six back-to-back channel beats
    p = pulseCnt[1];
    for (int c = 0; c < 6; c++) beat(1, fill(16'h0010), 16'h0000);
    idle(6);
    check("t2 pulses", pulseCnt[1] - p, 1);
    check("t2 data", {16'b0, lastOut[1]}, 32'h0960);

    // 3: same frame with random gaps
    p = pulseCnt[1];
    for (int c = 0; c < 6; c++) begin
      beat(1, fill(16'h0010), 16'h0000);
      idle($urandom_range(1, 3));
    end
    idle(5);
    check("t3 pulses", pulseCnt[1] - p, 1);
    check("t3 data", {16'b0, lastOut[1]}, 32'h0960);

    // 4: saturation both ways
    beat(0, fill(16'h7FFF), 16'h0000);
    idle(5);
    check("t4 sat max", {16'b0, lastOut[0]}, 32'h7FFF);
    beat(0, fill(16'h8000), 16'h0000);
    idle(5);
`ifdef CONV_ACC_RELU_EN
    expNeg = 16'h0000;
`else
    expNeg = 16'h8000;
`endif
    check("t4 sat min", {16'b0, lastOut[0]}, {16'b0, expNeg});

    // Element placement: ramp 1..25 LSBs sums to 325
    for (int k = 0; k < N; k++) v[W*k +: W] = 16'(k + 1);
    beat(0, v, 16'h0000);
    idle(5);
    check("ramp data", {16'b0, lastOut[0]}, 32'h0145);

    // Mixed signs: 13 * -1.0 + 12 * 2.0 - 0.5 = 10.5
    for (int k = 0; k < N; k++) v[W*k +: W] = (k % 2 == 0) ? 16'hFF00 : 16'h0200;
    beat(0, v, 16'hFF80);
    idle(5);
    check("mixed data", {16'b0, lastOut[0]}, 32'h0A80);

    // 5: reset mid-frame, then clean frames
    p = pulseCnt[1];
    abortFrame(16'h0100);
    check("t5 busy after rst", {31'b0, busy[1]}, 32'h0);
    for (int c = 0; c < 6; c++) beat(1, fill(16'h0100), 16'h0000);
    idle(6);
    check("t5a pulses", pulseCnt[1] - p, 1);
    check("t5a data", {16'b0, lastOut[1]}, 32'h7FFF);
    p = pulseCnt[1];
    abortFrame(16'h0008);
    for (int c = 0; c < 6; c++) beat(1, fill(16'h0008), 16'h0000);
    idle(6);
    check("t5b pulses", pulseCnt[1] - p, 1);
    check("t5b data", {16'b0, lastOut[1]}, 32'h04B0);

    // 6: two frames with no bubble; bias on non-last beats must be ignored
    p = pulseCnt[1];
    for (int c = 0; c < 6; c++) beat(1, fill(16'h0010), (c == 5) ? 16'h0100 : 16'h1234);
    for (int c = 0; c < 6; c++) beat(1, fill(16'h0010), (c == 5) ? 16'hFF00 : 16'h1234);
    idle(6);
    check("t6 pulses", pulseCnt[1] - p, 2);
    check("t6 frame1", {16'b0, prevOut[1]}, 32'h0A60);
    check("t6 frame2", {16'b0, lastOut[1]}, 32'h0860);
    check("t6 spacing", lastCyc[1] - prevCyc[1], 6);

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
